// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: issue/writeback control wrapped around a clocked 8-bit alu.
// Owns a 4x8 register file; load-immediate and halt never touch the alu.
module alu_issue_ctrl #(
   parameter int         ALU_LATENCY = 1,
   parameter logic [3:0] HALT_OP     = 4'b1111,
   parameter logic [3:0] LDI_OP      = 4'b1110
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       instr_valid,
   output logic       instr_ready,
   input  logic [15:0] instr,
   output logic       enable_alu,
   output logic [3:0] alu_opcode,
   output logic [7:0] alu_in_a,
   output logic [7:0] alu_in_b,
   output logic [7:0] alu_shamp,
   input  logic [7:0] alu_out,
   input  logic       alu_flag_zero,
   input  logic       alu_flag_carry,
   output logic       wb_valid,
   output logic [1:0] wb_rd,
   output logic [7:0] wb_data,
   output logic       flag_zero,
   output logic       flag_carry,
   output logic       halted
);

   typedef enum logic [2:0] {IDLE, ISSUE, WAIT, WB, HALTED} state_t;

   localparam logic [1:0] CNT_INIT = 2'(ALU_LATENCY - 1);

   state_t     state, state_n;
   logic [7:0] regs [4];
   logic [1:0] rd_q;
   logic [1:0] cnt;
   logic [3:0] op;
   logic [1:0] rd, rs;
   logic [7:0] imm;
   logic       xfer;
   logic       alu_done;

   assign {op, rd, rs, imm} = instr;
   assign xfer     = instr_valid && instr_ready;
   assign alu_done = (state == WAIT) && (cnt == 2'd0);

   always_comb begin
      state_n = state;
      case (state)
         IDLE: begin
            if (xfer) begin
               if (op == HALT_OP)     state_n = HALTED;
               else if (op == LDI_OP) state_n = WB;
               else                   state_n = ISSUE;
            end
         end
         ISSUE:   state_n = WAIT;
         WAIT:    if (cnt == 2'd0) state_n = WB;
         WB:      state_n = IDLE;
         HALTED:  state_n = HALTED;
         default: state_n = IDLE;
      endcase
   end

   // All handshake/status outputs are registered from the next state,
   // so instr_ready has no combinational path from instr_valid.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         instr_ready <= 1'b1;
         enable_alu  <= 1'b0;
         wb_valid    <= 1'b0;
         halted      <= 1'b0;
         alu_opcode  <= '0;
         alu_in_a    <= '0;
         alu_in_b    <= '0;
         alu_shamp   <= '0;
         wb_rd       <= '0;
         wb_data     <= '0;
         flag_zero   <= 1'b0;
         flag_carry  <= 1'b0;
         rd_q        <= '0;
         cnt         <= '0;
         for (int i = 0; i < 4; i++) regs[i] <= '0;
      end else begin
         state       <= state_n;
         instr_ready <= (state_n == IDLE);
         enable_alu  <= (state_n == ISSUE);
         wb_valid    <= (state_n == WB);
         halted      <= (state_n == HALTED);
         if (xfer) begin
            rd_q <= rd;
            if (op == LDI_OP) begin
               regs[rd] <= imm;
               wb_rd    <= rd;
               wb_data  <= imm;
            end else if (op != HALT_OP) begin
               alu_opcode <= op;
               alu_in_a   <= regs[rd];
               alu_in_b   <= regs[rs];
               alu_shamp  <= imm;
            end
         end
         if (state == ISSUE)
            cnt <= CNT_INIT;
         else if (state == WAIT && cnt != 2'd0)
            cnt <= cnt - 2'd1;
         if (alu_done) begin
            regs[rd_q] <= alu_out;
            wb_rd      <= rd_q;
            wb_data    <= alu_out;
            flag_zero  <= alu_flag_zero;
            flag_carry <= alu_flag_carry;
         end
      end
   end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb_alu_issue_ctrl: directed checks of alu_issue_ctrl with a simple
// registered alu model at latency 1 (main DUT) and latency 3 (second DUT).
module tb_alu_issue_ctrl;

   logic       clk;
   logic       rst_n;
   logic       instr_valid, instr_ready;
   logic [15:0] instr;
   logic       enable_alu;
   logic [3:0] alu_opcode;
   logic [7:0] alu_in_a, alu_in_b, alu_shamp, alu_out;
   logic       alu_flag_zero, alu_flag_carry;
   logic       wb_valid;
   logic [1:0] wb_rd;
   logic [7:0] wb_data;
   logic       flag_zero, flag_carry, halted;

   logic       v3, ready3;
   logic [15:0] instr3;
   logic       en3;
   logic [3:0] op3;
   logic [7:0] a3, b3, sh3, out3;
   logic       fz3, fc3;
   logic       wbv3;
   logic [1:0] wbrd3;
   logic [7:0] wbd3;
   logic       z3, c3, h3;

   int errors = 0;
   int checks = 0;

   alu_issue_ctrl #(.ALU_LATENCY(1)) dut (
      .clk(clk), .rst_n(rst_n),
      .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr),
      .enable_alu(enable_alu), .alu_opcode(alu_opcode),
      .alu_in_a(alu_in_a), .alu_in_b(alu_in_b), .alu_shamp(alu_shamp),
      .alu_out(alu_out), .alu_flag_zero(alu_flag_zero),
      .alu_flag_carry(alu_flag_carry),
      .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
      .flag_zero(flag_zero), .flag_carry(flag_carry), .halted(halted)
   );

   alu_issue_ctrl #(.ALU_LATENCY(3)) dut3 (
      .clk(clk), .rst_n(rst_n),
      .instr_valid(v3), .instr_ready(ready3), .instr(instr3),
      .enable_alu(en3), .alu_opcode(op3),
      .alu_in_a(a3), .alu_in_b(b3), .alu_shamp(sh3),
      .alu_out(out3), .alu_flag_zero(fz3), .alu_flag_carry(fc3),
      .wb_valid(wbv3), .wb_rd(wbrd3), .wb_data(wbd3),
      .flag_zero(z3), .flag_carry(c3), .halted(h3)
   );

   // {zero, carry, result}
   function automatic logic [9:0] alu_f(logic [3:0] op, logic [7:0] a,
                                        logic [7:0] b);
      logic [8:0] s;
      case (op)
         4'b0010: s = {1'b0, a} + {1'b0, b};
         4'b0001: s = {1'b0, a & b};
         default: s = {1'b0, a};
      endcase
      return {s[7:0] == 8'd0, s[8], s[7:0]};
   endfunction

   logic [9:0] m1 = '0;
   logic [9:0] p0 = '0, p1 = '0, p2 = '0;

   always @(posedge clk) begin
      if (enable_alu) m1 <= alu_f(alu_opcode, alu_in_a, alu_in_b);
      if (en3) p0 <= alu_f(op3, a3, b3);
      p1 <= p0;
      p2 <= p1;
   end

   assign {alu_flag_zero, alu_flag_carry, alu_out} = m1;
   assign {fz3, fc3, out3} = p2;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [3:0] op, input logic [1:0] rd,
                       input logic [1:0] rs, input logic [7:0] imm);
      instr_valid = 1'b1;
      instr = {op, rd, rs, imm};
      tick();
      instr_valid = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      instr_valid = 1'b0;
      instr = '0;
      v3 = 1'b0;
      instr3 = '0;
      #12;
      tick();
      checks++;
      if ({instr_ready, enable_alu, wb_valid, halted} !== 4'b1000) begin
         errors++;
         $display("FAIL rst_ctrl: got %b want 1000",
                  {instr_ready, enable_alu, wb_valid, halted});
      end
      checks++;
      if ({alu_opcode, alu_in_a, alu_in_b, alu_shamp} !== 28'd0) begin
         errors++;
         $display("FAIL rst_alu: got %h want 0",
                  {alu_opcode, alu_in_a, alu_in_b, alu_shamp});
      end
      checks++;
      if ({wb_rd, wb_data, flag_zero, flag_carry} !== 12'd0) begin
         errors++;
         $display("FAIL rst_wb: got %h want 0",
                  {wb_rd, wb_data, flag_zero, flag_carry});
      end
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_ldi();
      send(4'b1110, 2'd0, 2'd0, 8'd240);
      checks++;
      if ({wb_valid, wb_rd, wb_data} !== {1'b1, 2'd0, 8'd240}) begin
         errors++;
         $display("FAIL ldi0_wb: got %b/%0d/%0d want 1/0/240",
                  wb_valid, wb_rd, wb_data);
      end
      tick();
      checks++;
      if ({wb_valid, instr_ready} !== 2'b01) begin
         errors++;
         $display("FAIL ldi0_after: got %b want 01", {wb_valid, instr_ready});
      end
      send(4'b1110, 2'd1, 2'd0, 8'd30);
      checks++;
      if ({wb_valid, wb_rd, wb_data} !== {1'b1, 2'd1, 8'd30}) begin
         errors++;
         $display("FAIL ldi1_wb: got %b/%0d/%0d want 1/1/30",
                  wb_valid, wb_rd, wb_data);
      end
      checks++;
      if ({flag_zero, flag_carry} !== 2'b00) begin
         errors++;
         $display("FAIL ldi_flags: got %b want 00", {flag_zero, flag_carry});
      end
      tick();
   endtask

   task automatic test_add();
      send(4'b0010, 2'd0, 2'd1, 8'h00);
      checks++;
      if ({enable_alu, alu_opcode, alu_in_a, alu_in_b} !==
          {1'b1, 4'b0010, 8'd240, 8'd30}) begin
         errors++;
         $display("FAIL add_issue: got %b/%h/%0d/%0d want 1/2/240/30",
                  enable_alu, alu_opcode, alu_in_a, alu_in_b);
      end
      tick();
      checks++;
      if ({enable_alu, wb_valid, alu_in_a} !== {2'b00, 8'd240}) begin
         errors++;
         $display("FAIL add_wait: got %b/%b/%0d want 0/0/240",
                  enable_alu, wb_valid, alu_in_a);
      end
      tick();
      checks++;
      if ({wb_valid, wb_rd, wb_data, flag_zero, flag_carry, instr_ready} !==
          {1'b1, 2'd0, 8'd14, 1'b0, 1'b1, 1'b0}) begin
         errors++;
         $display("FAIL add_wb: got v%b rd%0d d%0d z%b c%b r%b want 1/0/14/0/1/0",
                  wb_valid, wb_rd, wb_data, flag_zero, flag_carry, instr_ready);
      end
      tick();
      checks++;
      if ({wb_valid, instr_ready, wb_data} !== {2'b01, 8'd14}) begin
         errors++;
         $display("FAIL add_after: got %b/%b/%0d want 0/1/14",
                  wb_valid, instr_ready, wb_data);
      end
   endtask

   task automatic test_zero();
      int n;
      send(4'b1110, 2'd2, 2'd0, 8'd0);
      tick();
      send(4'b1110, 2'd3, 2'd0, 8'd0);
      tick();
      send(4'b0010, 2'd2, 2'd3, 8'h5a);
      checks++;
      if (alu_shamp !== 8'h5a) begin
         errors++;
         $display("FAIL zero_shamp: got %h want 5a", alu_shamp);
      end
      tick();
      tick();
      checks++;
      if ({wb_valid, wb_rd, wb_data, flag_zero, flag_carry} !==
          {1'b1, 2'd2, 8'd0, 1'b1, 1'b0}) begin
         errors++;
         $display("FAIL zero_wb: got v%b rd%0d d%0d z%b c%b want 1/2/0/1/0",
                  wb_valid, wb_rd, wb_data, flag_zero, flag_carry);
      end
      tick();
      v3 = 1'b1;
      instr3 = {4'b0010, 2'd2, 2'd3, 8'h00};
      tick();
      v3 = 1'b0;
      n = 1;
      while (!wbv3 && n < 20) begin
         tick();
         n++;
      end
      checks++;
      if (n !== 5) begin
         errors++;
         $display("FAIL lat3_timing: got %0d want 5", n);
      end
      checks++;
      if ({wbd3, z3, c3} !== {8'd0, 1'b1, 1'b0}) begin
         errors++;
         $display("FAIL lat3_wb: got d%0d z%b c%b want 0/1/0", wbd3, z3, c3);
      end
      tick();
   endtask

   task automatic test_back_to_back();
      logic [15:0] prog [3];
      logic [1:0]  exp_rd [3];
      logic [7:0]  exp_d [3];
      int xfers, wbs, ens, bad;
      bit go;
      prog   = '{16'h2400, 16'h2900, 16'h2200};
      exp_rd = '{2'd1, 2'd2, 2'd0};
      exp_d  = '{8'd44, 8'd44, 8'd58};
      xfers = 0; wbs = 0; ens = 0; bad = 0;
      instr_valid = 1'b1;
      instr = prog[0];
      for (int c = 0; c < 40; c++) begin
         go = instr_ready && instr_valid;
         tick();
         if (go) begin
            xfers++;
            if (xfers < 3) instr = prog[xfers];
            else instr_valid = 1'b0;
         end
         if (enable_alu) begin
            ens++;
            if (instr_ready) bad++;
         end
         if (wb_valid) begin
            if (instr_ready) bad++;
            if (wbs < 3) begin
               checks++;
               if ({wb_rd, wb_data} !== {exp_rd[wbs], exp_d[wbs]}) begin
                  errors++;
                  $display("FAIL b2b_wb%0d: got rd%0d d%0d want rd%0d d%0d",
                           wbs, wb_rd, wb_data, exp_rd[wbs], exp_d[wbs]);
               end
            end
            wbs++;
         end
      end
      instr_valid = 1'b0;
      checks++;
      if (xfers !== 3 || wbs !== 3 || ens !== 3) begin
         errors++;
         $display("FAIL b2b_count: got x%0d w%0d e%0d want 3/3/3",
                  xfers, wbs, ens);
      end
      checks++;
      if (bad !== 0) begin
         errors++;
         $display("FAIL b2b_ready: got %0d busy-ready cycles want 0", bad);
      end
   endtask

   task automatic test_reset_midop();
      int wbs;
      send(4'b0010, 2'd0, 2'd1, 8'h11);
      tick();
      rst_n = 1'b0;
      #1;
      checks++;
      if ({instr_ready, enable_alu, wb_valid, halted, alu_in_a, alu_shamp,
           wb_data, flag_zero, flag_carry} !== {4'b1000, 26'd0}) begin
         errors++;
         $display("FAIL midrst_outs: rdy%b en%b wbv%b a%0d sh%0d d%0d",
                  instr_ready, enable_alu, wb_valid, alu_in_a, alu_shamp,
                  wb_data);
      end
      tick();
      rst_n = 1'b1;
      wbs = 0;
      for (int i = 0; i < 4; i++) begin
         tick();
         if (wb_valid) wbs++;
      end
      checks++;
      if (wbs !== 0) begin
         errors++;
         $display("FAIL midrst_nowb: got %0d pulses want 0", wbs);
      end
      send(4'b0010, 2'd0, 2'd1, 8'h00);
      tick();
      tick();
      checks++;
      if ({wb_valid, wb_data, flag_zero} !== {1'b1, 8'd0, 1'b1}) begin
         errors++;
         $display("FAIL midrst_regs: got v%b d%0d z%b want 1/0/1",
                  wb_valid, wb_data, flag_zero);
      end
      tick();
   endtask

   task automatic test_halt();
      int wbs;
      send(4'b1111, 2'd0, 2'd0, 8'h00);
      checks++;
      if ({halted, instr_ready, wb_valid} !== 3'b100) begin
         errors++;
         $display("FAIL halt_enter: got %b want 100",
                  {halted, instr_ready, wb_valid});
      end
      instr_valid = 1'b1;
      instr = {4'b1110, 2'd1, 2'd0, 8'h77};
      wbs = 0;
      for (int i = 0; i < 5; i++) begin
         tick();
         if (wb_valid || !halted || instr_ready) wbs++;
      end
      instr_valid = 1'b0;
      checks++;
      if (wbs !== 0) begin
         errors++;
         $display("FAIL halt_hold: got %0d bad cycles want 0", wbs);
      end
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      tick();
      checks++;
      if ({halted, instr_ready} !== 2'b01) begin
         errors++;
         $display("FAIL halt_reset: got %b want 01", {halted, instr_ready});
      end
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_ldi();
      test_add();
      test_zero();
      test_back_to_back();
      test_reset_midop();
      test_halt();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
